// File: rtl/rv_ctrl_pkg.sv
// RV32I(+M) control encodings and the ID/EX control bundle shared by decoder and pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JAL    = 2'b10;
    localparam logic [1:0] NPC_JALR   = 2'b11;

    localparam logic [1:0] WSEL_ALU   = 2'b00;
    localparam logic [1:0] WSEL_RAM   = 2'b01;
    localparam logic [1:0] WSEL_PC4   = 2'b10;
    localparam logic [1:0] WSEL_IMM   = 2'b11;

    localparam logic [2:0] SEXT_I     = 3'd0;
    localparam logic [2:0] SEXT_S     = 3'd1;
    localparam logic [2:0] SEXT_B     = 3'd2;
    localparam logic [2:0] SEXT_U     = 3'd3;
    localparam logic [2:0] SEXT_J     = 3'd4;
    localparam logic [2:0] SEXT_SHAMT = 3'd5;

    localparam int ALU_W = 5;

    localparam logic [ALU_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_W-1:0] ALU_SLL    = 5'd2;
    localparam logic [ALU_W-1:0] ALU_SLT    = 5'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU   = 5'd4;
    localparam logic [ALU_W-1:0] ALU_XOR    = 5'd5;
    localparam logic [ALU_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_W-1:0] ALU_OR     = 5'd8;
    localparam logic [ALU_W-1:0] ALU_AND    = 5'd9;
    localparam logic [ALU_W-1:0] ALU_BEQ    = 5'd10;
    localparam logic [ALU_W-1:0] ALU_BNE    = 5'd11;
    localparam logic [ALU_W-1:0] ALU_BLT    = 5'd12;
    localparam logic [ALU_W-1:0] ALU_BGE    = 5'd13;
    localparam logic [ALU_W-1:0] ALU_BLTU   = 5'd14;
    localparam logic [ALU_W-1:0] ALU_BGEU   = 5'd15;
    // M-extension codes are 5'b10 followed by funct3, MUL..REMU in order.
    localparam logic [ALU_W-1:0] ALU_MUL    = 5'd16;
    localparam logic [ALU_W-1:0] ALU_MULH   = 5'd17;
    localparam logic [ALU_W-1:0] ALU_MULHSU = 5'd18;
    localparam logic [ALU_W-1:0] ALU_MULHU  = 5'd19;
    localparam logic [ALU_W-1:0] ALU_DIV    = 5'd20;
    localparam logic [ALU_W-1:0] ALU_DIVU   = 5'd21;
    localparam logic [ALU_W-1:0] ALU_REM    = 5'd22;
    localparam logic [ALU_W-1:0] ALU_REMU   = 5'd23;

    typedef struct packed {
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [1:0]       npc_op;
        logic [1:0]       rf_wsel;
        logic             rf_we;
        logic             ram_we;
        logic             is_load;
        logic [ALU_W-1:0] alu_op;
        logic             alua_sel;
        logic             alub_sel;
        logic [2:0]       sext_op;
        logic             illegal;
    } ctrl_t;

    function automatic logic [ALU_W-1:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [ALU_W-1:0] branch_alu(input logic [2:0] f3);
        case (f3)
            3'b001:  return ALU_BNE;
            3'b100:  return ALU_BLT;
            3'b101:  return ALU_BGE;
            3'b110:  return ALU_BLTU;
            3'b111:  return ALU_BGEU;
            default: return ALU_BEQ;
        endcase
    endfunction

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I(+M) decoder: instruction word -> control bundle and source-use flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inst continuously.
module rv_decode
    import rv_ctrl_pkg::*;
#(
    parameter bit EN_MEXT = 1'b1
) (
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      c;
    logic       wr;
    logic       ill;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

    always_comb begin
        c         = '0;
        c.rs1     = inst[19:15];
        c.rs2     = inst[24:20];
        c.rd      = inst[11:7];
        wr        = 1'b0;
        ill       = 1'b0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;

        case (opcode)
            OPC_LUI: begin
                c.rf_wsel  = WSEL_IMM;
                c.alub_sel = 1'b1;
                c.sext_op  = SEXT_U;
                wr         = 1'b1;
                uses_rs1   = 1'b0;
            end
            OPC_AUIPC: begin
                c.alua_sel = 1'b1;
                c.alub_sel = 1'b1;
                c.sext_op  = SEXT_U;
                wr         = 1'b1;
                uses_rs1   = 1'b0;
            end
            OPC_JAL: begin
                c.npc_op   = NPC_JAL;
                c.rf_wsel  = WSEL_PC4;
                c.alua_sel = 1'b1;
                c.alub_sel = 1'b1;
                c.sext_op  = SEXT_J;
                wr         = 1'b1;
                uses_rs1   = 1'b0;
            end
            OPC_JALR: begin
                c.npc_op   = NPC_JALR;
                c.rf_wsel  = WSEL_PC4;
                c.alub_sel = 1'b1;
                c.sext_op  = SEXT_I;
                wr         = 1'b1;
            end
            OPC_BRANCH: begin
                c.npc_op   = NPC_BRANCH;
                c.alu_op   = branch_alu(f3);
                c.sext_op  = SEXT_B;
                uses_rs2   = 1'b1;
            end
            OPC_LOAD: begin
                c.is_load  = 1'b1;
                c.rf_wsel  = WSEL_RAM;
                c.alub_sel = 1'b1;
                c.sext_op  = SEXT_I;
                wr         = 1'b1;
            end
            OPC_STORE: begin
                c.ram_we   = 1'b1;
                c.alub_sel = 1'b1;
                c.sext_op  = SEXT_S;
                uses_rs2   = 1'b1;
            end
            OPC_IMM: begin
                c.alub_sel = 1'b1;
                c.sext_op  = SEXT_I;
                wr         = 1'b1;
                case (f3)
                    3'b001: begin
                        c.alu_op  = ALU_SLL;
                        c.sext_op = SEXT_SHAMT;
                    end
                    3'b101: begin
                        c.alu_op  = inst[30] ? ALU_SRA : ALU_SRL;
                        c.sext_op = SEXT_SHAMT;
                    end
                    default: c.alu_op = alu_base(f3);
                endcase
            end
            OPC_OP: begin
                wr       = 1'b1;
                uses_rs2 = 1'b1;
                if (f7 == 7'b0000000)
                    c.alu_op = alu_base(f3);
                else if (f7 == 7'b0100000 && f3 == 3'b000)
                    c.alu_op = ALU_SUB;
                else if (f7 == 7'b0100000 && f3 == 3'b101)
                    c.alu_op = ALU_SRA;
                else if (f7 == 7'b0000001 && EN_MEXT)
                    c.alu_op = {2'b10, f3};
                else
                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase

        // An illegal instruction travels as a harmless NOP that only raises the flag.
        if (ill) begin
            c.npc_op   = NPC_PC4;
            c.rf_wsel  = WSEL_ALU;
            c.ram_we   = 1'b0;
            c.is_load  = 1'b0;
            c.alu_op   = ALU_ADD;
            c.alua_sel = 1'b0;
            c.alub_sel = 1'b0;
            c.sext_op  = SEXT_I;
            c.illegal  = 1'b1;
        end
        c.rf_we = wr & ~ill & (c.rd != 5'd0);
        ctrl    = c;
    end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ID-stage decode plus ID/EX control register with load-use bubble, EX flush and saturating stall counter.
// Latency: 1 cycle from ID acceptance to ex_* outputs.
// Backpressure: mem_stall holds ID/EX; a load-use hazard holds ID for one bubble; ex_flush overrides both.
module id_ex_ctrl_pipe
    import rv_ctrl_pkg::*;
#(
    parameter bit EN_MEXT  = 1'b1,
    parameter int ALU_OP_W = 5,
    parameter int CNT_W    = 32
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst_n,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [31:0]         id_inst,
    input  logic [31:0]         id_pc,
    input  logic                ex_flush,
    input  logic                mem_stall,
    output logic                ex_valid,
    output logic [31:0]         ex_pc,
    output logic [4:0]          ex_rs1,
    output logic [4:0]          ex_rs2,
    output logic [4:0]          ex_rd,
    output logic [1:0]          ex_npc_op,
    output logic [1:0]          ex_rf_wsel,
    output logic                ex_rf_we,
    output logic                ex_ram_we,
    output logic                ex_is_load,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alua_sel,
    output logic                ex_alub_sel,
    output logic [2:0]          ex_sext_op,
    output logic                ex_illegal,
    output logic [CNT_W-1:0]    stall_cnt
);

    ctrl_t id_ctrl;
    ctrl_t ex_q;
    logic  uses_rs1;
    logic  uses_rs2;
    logic  haz;

    rv_decode #(
        .EN_MEXT (EN_MEXT)
    ) u_decode (
        .inst     (id_inst),
        .ctrl     (id_ctrl),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // Load in EX whose result is needed by the instruction sitting in ID.
    assign haz = ex_valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                 ((uses_rs1 && (id_ctrl.rs1 == ex_q.rd)) ||
                  (uses_rs2 && (id_ctrl.rs2 == ex_q.rd)));

    assign id_ready = (~mem_stall & ~haz) | ex_flush;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_q     <= '0;
        end else if (ex_flush) begin
            ex_valid <= 1'b0;
        end else if (!mem_stall) begin
            if (haz) begin
                ex_valid <= 1'b0;
            end else if (id_valid) begin
                ex_valid <= 1'b1;
                ex_pc    <= id_pc;
                ex_q     <= id_ctrl;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n)
            stall_cnt <= '0;
        else if (id_valid && !id_ready && !ex_flush && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    // Side-effecting fields are qualified so a stale bundle behind a bubble is inert.
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_npc_op   = ex_valid ? ex_q.npc_op : NPC_PC4;
    assign ex_rf_wsel  = ex_q.rf_wsel;
    assign ex_rf_we    = ex_valid & ex_q.rf_we;
    assign ex_ram_we   = ex_valid & ex_q.ram_we;
    assign ex_is_load  = ex_valid & ex_q.is_load;
    assign ex_alu_op   = ALU_OP_W'(ex_q.alu_op);
    assign ex_alua_sel = ex_q.alua_sel;
    assign ex_alub_sel = ex_q.alub_sel;
    assign ex_sext_op  = ex_q.sext_op;
    assign ex_illegal  = ex_valid & ex_q.illegal;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Self-checking bench for id_ex_ctrl_pipe: decode table through a scoreboard plus hazard/flush/hold/reset sequences.
module tb_id_ex_ctrl_pipe;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_inst = '0;
    logic [31:0] id_pc = '0;
    logic        ex_flush = 1'b0;
    logic        mem_stall = 1'b0;

    logic        id_ready, ex_valid, ex_rf_we, ex_ram_we, ex_is_load, ex_alua_sel, ex_alub_sel, ex_illegal;
    logic [31:0] ex_pc, stall_cnt;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_alu_op;
    logic [1:0]  ex_npc_op, ex_rf_wsel;
    logic [2:0]  ex_sext_op;

    logic        n_id_ready, n_ex_valid, n_ex_rf_we, n_ex_ram_we, n_ex_is_load, n_ex_alua_sel, n_ex_alub_sel, n_ex_illegal;
    logic [31:0] n_ex_pc, n_stall_cnt;
    logic [4:0]  n_ex_rs1, n_ex_rs2, n_ex_rd, n_ex_alu_op;
    logic [1:0]  n_ex_npc_op, n_ex_rf_wsel;
    logic [2:0]  n_ex_sext_op;

    always #5 cpu_clk = ~cpu_clk;

    id_ex_ctrl_pipe #(.EN_MEXT(1'b1), .ALU_OP_W(5), .CNT_W(32)) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_pc(id_pc), .ex_flush(ex_flush), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_npc_op(ex_npc_op), .ex_rf_wsel(ex_rf_wsel), .ex_rf_we(ex_rf_we), .ex_ram_we(ex_ram_we),
        .ex_is_load(ex_is_load), .ex_alu_op(ex_alu_op), .ex_alua_sel(ex_alua_sel),
        .ex_alub_sel(ex_alub_sel), .ex_sext_op(ex_sext_op), .ex_illegal(ex_illegal),
        .stall_cnt(stall_cnt)
    );

    id_ex_ctrl_pipe #(.EN_MEXT(1'b0), .ALU_OP_W(5), .CNT_W(32)) dut_nm (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .id_valid(id_valid), .id_ready(n_id_ready),
        .id_inst(id_inst), .id_pc(id_pc), .ex_flush(ex_flush), .mem_stall(mem_stall),
        .ex_valid(n_ex_valid), .ex_pc(n_ex_pc), .ex_rs1(n_ex_rs1), .ex_rs2(n_ex_rs2), .ex_rd(n_ex_rd),
        .ex_npc_op(n_ex_npc_op), .ex_rf_wsel(n_ex_rf_wsel), .ex_rf_we(n_ex_rf_we), .ex_ram_we(n_ex_ram_we),
        .ex_is_load(n_ex_is_load), .ex_alu_op(n_ex_alu_op), .ex_alua_sel(n_ex_alua_sel),
        .ex_alub_sel(n_ex_alub_sel), .ex_sext_op(n_ex_sext_op), .ex_illegal(n_ex_illegal),
        .stall_cnt(n_stall_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  npc, wsel;
        logic        rf_we, ram_we, is_load;
        logic [4:0]  alu;
        logic        alua, alub;
        logic [2:0]  sext;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst;
        exp_t        e;
    } vec_t;

    localparam int NV = 15;
    localparam logic [31:0] I_MUL    = 32'h022081B3;
    localparam logic [31:0] I_LW_X5  = 32'h0000A283;
    localparam logic [31:0] I_ADD_X5 = 32'h00228333;

    vec_t tbl[NV];
    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    logic last_ms = 1'b0;

    function automatic vec_t v(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [1:0] npc, input logic [1:0] wsel,
                               input logic we, input logic ramwe, input logic ld,
                               input logic [4:0] alu, input logic a, input logic b,
                               input logic [2:0] sx, input logic ill);
        vec_t r;
        r.inst = inst;      r.e.pc = pc;        r.e.rs1 = rs1;      r.e.rs2 = rs2;
        r.e.rd = rd;        r.e.npc = npc;      r.e.wsel = wsel;    r.e.rf_we = we;
        r.e.ram_we = ramwe; r.e.is_load = ld;   r.e.alu = alu;      r.e.alua = a;
        r.e.alub = b;       r.e.sext = sx;      r.e.ill = ill;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Scoreboard monitor: a fresh instruction is in EX when valid and the previous edge was not a hold.
    always @(negedge cpu_clk) begin : mon
        exp_t got;
        exp_t want;
        if (!cpu_rst_n) begin
            last_ms = 1'b0;
        end else begin
            if (ex_valid && !last_ms) begin
                got = {ex_pc, ex_rs1, ex_rs2, ex_rd, ex_npc_op, ex_rf_wsel, ex_rf_we, ex_ram_we,
                       ex_is_load, ex_alu_op, ex_alua_sel, ex_alub_sel, ex_sext_op, ex_illegal};
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got instruction at pc %h, required none", ex_pc);
                end else begin
                    want = expq.pop_front();
                    chk("sb_bundle", got, want);
                end
            end
            last_ms = mem_stall;
        end
    end

    task automatic tick;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
        id_valid = 1'b1;
        id_inst  = inst;
        id_pc    = pc;
    endtask

    task automatic do_reset;
        id_valid  = 1'b0;
        ex_flush  = 1'b0;
        mem_stall = 1'b0;
        #2 cpu_rst_n = 1'b0;
        expq.delete();
        @(posedge cpu_clk);
        #1 cpu_rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = v(32'h00228333, 32'h1000,  5,  2,  6, 2'd0, 2'd0, 1, 0, 0,  5'd0, 0, 0, 3'd0, 0);
        tbl[1]  = v(32'h402083B3, 32'h1004,  1,  2,  7, 2'd0, 2'd0, 1, 0, 0,  5'd1, 0, 0, 3'd0, 0);
        tbl[2]  = v(I_MUL,        32'h1008,  1,  2,  3, 2'd0, 2'd0, 1, 0, 0, 5'd16, 0, 0, 3'd0, 0);
        tbl[3]  = v(32'h0041A433, 32'h100C,  3,  4,  8, 2'd0, 2'd0, 1, 0, 0,  5'd3, 0, 0, 3'd0, 0);
        tbl[4]  = v(32'h00500513, 32'h1010,  0,  5, 10, 2'd0, 2'd0, 1, 0, 0,  5'd0, 0, 1, 3'd0, 0);
        tbl[5]  = v(32'h40355593, 32'h1014, 10,  3, 11, 2'd0, 2'd0, 1, 0, 0,  5'd7, 0, 1, 3'd5, 0);
        tbl[6]  = v(I_LW_X5,      32'h1018,  1,  0,  5, 2'd0, 2'd1, 1, 0, 1,  5'd0, 0, 1, 3'd0, 0);
        tbl[7]  = v(32'h0020A423, 32'h101C,  1,  2,  8, 2'd0, 2'd0, 0, 1, 0,  5'd0, 0, 1, 3'd1, 0);
        tbl[8]  = v(32'h00208863, 32'h1020,  1,  2, 16, 2'd1, 2'd0, 0, 0, 0, 5'd10, 0, 0, 3'd2, 0);
        tbl[9]  = v(32'h008000EF, 32'h1024,  0,  8,  1, 2'd2, 2'd2, 1, 0, 0,  5'd0, 1, 1, 3'd4, 0);
        tbl[10] = v(32'h00008067, 32'h1028,  1,  0,  0, 2'd3, 2'd2, 0, 0, 0,  5'd0, 0, 1, 3'd0, 0);
        tbl[11] = v(32'h12345237, 32'h102C,  8,  3,  4, 2'd0, 2'd3, 1, 0, 0,  5'd0, 0, 1, 3'd3, 0);
        tbl[12] = v(32'h00001297, 32'h1030,  0,  0,  5, 2'd0, 2'd0, 1, 0, 0,  5'd0, 1, 1, 3'd3, 0);
        tbl[13] = v(32'hFFFFFFFF, 32'h1034, 31, 31, 31, 2'd0, 2'd0, 0, 0, 0,  5'd0, 0, 0, 3'd0, 1);
        tbl[14] = v(32'h04208333, 32'h1038,  1,  2,  6, 2'd0, 2'd0, 0, 0, 0,  5'd0, 0, 0, 3'd0, 1);

        // Asynchronous reset seen before any clock edge.
        #3 cpu_rst_n = 1'b0;
        #1;
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ctrl", {ex_npc_op, ex_rf_we, ex_ram_we, ex_alu_op, ex_sext_op}, 13'd0);
        @(posedge cpu_clk);
        #1 cpu_rst_n = 1'b1;

        // Decode table, back-to-back with no stalls.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].inst, tbl[i].e.pc);
            expq.push_back(tbl[i].e);
            #1 chk("tbl_id_ready", id_ready, 1'b1);
            tick();
            if (tbl[i].inst == I_MUL) begin
                chk("nomext_illegal", n_ex_illegal, 1'b1);
                chk("nomext_rf_we", n_ex_rf_we, 1'b0);
                chk("nomext_valid", n_ex_valid, 1'b1);
            end
        end
        id_valid = 1'b0;
        tick();
        chk("tbl_drained", expq.size(), 0);

        // Load-use: exactly one bubble.
        do_reset();
        drive(I_LW_X5, 32'h100);
        expq.push_back(tbl[6].e);
        expq[0].pc = 32'h100;
        tick();
        chk("lu_lw_in_ex", ex_valid, 1'b1);
        drive(I_ADD_X5, 32'h104);
        expq.push_back(v(I_ADD_X5, 32'h104, 5, 2, 6, 2'd0, 2'd0, 1, 0, 0, 5'd0, 0, 0, 3'd0, 0).e);
        #1 chk("lu_ready_haz", id_ready, 1'b0);
        tick();
        chk("lu_bubble", ex_valid, 1'b0);
        chk("lu_cnt_bubble", stall_cnt, 32'd1);
        #1 chk("lu_ready_after", id_ready, 1'b1);
        tick();
        chk("lu_add_in_ex", {ex_valid, ex_pc}, {1'b1, 32'h104});
        chk("lu_cnt_final", stall_cnt, 32'd1);
        id_valid = 1'b0;
        tick();

        // No false hazard on a load to x0.
        do_reset();
        drive(32'h00002003, 32'h200);
        expq.push_back(v(32'h00002003, 32'h200, 0, 0, 0, 2'd0, 2'd1, 0, 0, 1, 5'd0, 0, 1, 3'd0, 0).e);
        tick();
        drive(32'h00200333, 32'h204);
        expq.push_back(v(32'h00200333, 32'h204, 0, 2, 6, 2'd0, 2'd0, 1, 0, 0, 5'd0, 0, 0, 3'd0, 0).e);
        #1 chk("x0_ready", id_ready, 1'b1);
        tick();
        chk("x0_add_in_ex", {ex_valid, ex_pc}, {1'b1, 32'h204});
        chk("x0_cnt", stall_cnt, 32'd0);
        id_valid = 1'b0;
        tick();

        // Flush beats mem_stall and the hazard; the ID instruction is dropped.
        do_reset();
        drive(I_LW_X5, 32'h100);
        expq.push_back(v(I_LW_X5, 32'h100, 1, 0, 5, 2'd0, 2'd1, 1, 0, 1, 5'd0, 0, 1, 3'd0, 0).e);
        tick();
        drive(I_ADD_X5, 32'h104);
        mem_stall = 1'b1;
        ex_flush  = 1'b1;
        #1 chk("fl_ready", id_ready, 1'b1);
        tick();
        chk("fl_ex_valid", ex_valid, 1'b0);
        chk("fl_cnt", stall_cnt, 32'd0);
        ex_flush  = 1'b0;
        mem_stall = 1'b0;
        id_valid  = 1'b0;
        tick();
        chk("fl_dropped", ex_valid, 1'b0);

        // Hold jal in EX for three mem_stall cycles.
        do_reset();
        drive(32'h008000EF, 32'h300);
        expq.push_back(v(32'h008000EF, 32'h300, 0, 8, 1, 2'd2, 2'd2, 1, 0, 0, 5'd0, 1, 1, 3'd4, 0).e);
        tick();
        drive(32'h00500513, 32'h304);
        expq.push_back(v(32'h00500513, 32'h304, 0, 5, 10, 2'd0, 2'd0, 1, 0, 0, 5'd0, 0, 1, 3'd0, 0).e);
        mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_jal", {ex_valid, ex_pc, ex_npc_op, ex_rd, ex_rf_we, ex_rf_wsel, ex_sext_op, ex_alua_sel},
                {1'b1, 32'h300, 2'd2, 5'd1, 1'b1, 2'd2, 3'd4, 1'b1});
        end
        chk("hold_cnt", stall_cnt, 32'd3);
        mem_stall = 1'b0;
        #1 chk("hold_release_ready", id_ready, 1'b1);
        tick();
        chk("hold_next_in_ex", {ex_valid, ex_pc}, {1'b1, 32'h304});
        id_valid = 1'b0;
        tick();

        // Reset in the middle of a stall wipes everything at once.
        do_reset();
        drive(I_LW_X5, 32'h400);
        expq.push_back(v(I_LW_X5, 32'h400, 1, 0, 5, 2'd0, 2'd1, 1, 0, 1, 5'd0, 0, 1, 3'd0, 0).e);
        tick();
        drive(I_ADD_X5, 32'h404);
        mem_stall = 1'b1;
        tick();
        tick();
        chk("rs_held_cnt", stall_cnt, 32'd2);
        #3 cpu_rst_n = 1'b0;
        #1;
        chk("rs_ex_valid", ex_valid, 1'b0);
        chk("rs_cnt", stall_cnt, 32'd0);
        chk("rs_is_load", ex_is_load, 1'b0);
        id_valid  = 1'b0;
        mem_stall = 1'b0;
        @(posedge cpu_clk);
        #1 cpu_rst_n = 1'b1;
        drive(I_ADD_X5, 32'h408);
        expq.push_back(v(I_ADD_X5, 32'h408, 5, 2, 6, 2'd0, 2'd0, 1, 0, 0, 5'd0, 0, 0, 3'd0, 0).e);
        #1 chk("rs_no_stale_haz", id_ready, 1'b1);
        tick();
        chk("rs_add_in_ex", {ex_valid, ex_pc}, {1'b1, 32'h408});
        id_valid = 1'b0;
        tick();
        tick();
        chk("sb_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
